// File: rtl/sad_min_tracker.sv
// Row-sum / SAD accumulator that keeps the smallest candidate SAD (and its index)
// over one search and reports it with a single-cycle done pulse.
module sad_min_tracker #(
   parameter int  ARRAY_SIZE = 16,
   parameter int  ROWS       = 16,
   parameter int  NUM_CAND   = 81,
   localparam int RS_W       = 8 + $clog2(ARRAY_SIZE),
   localparam int SAD_W      = RS_W + $clog2(ROWS),
   localparam int IDX_W      = $clog2(NUM_CAND)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    ad_valid,
   input  logic [ARRAY_SIZE*8-1:0] ad,
   output logic                    busy,
   output logic                    done,
   output logic [SAD_W-1:0]        best_sad,
   output logic [IDX_W-1:0]        best_idx
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
   localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(NUM_CAND - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
   logic [IDX_W-1:0]   cand_cnt_q, cand_cnt_d;

   // Stage 1: registered row sum plus the tags stage 2 needs to close a candidate.
   logic [RS_W-1:0]    rs_q, rs_d;
   logic               rs_valid_q, rs_valid_d;
   logic               rs_last_row_q, rs_last_row_d;
   logic               rs_last_cand_q, rs_last_cand_d;
   logic [IDX_W-1:0]   rs_cand_q, rs_cand_d;

   // Stage 2: running SAD of the current candidate and the best-so-far.
   logic [SAD_W-1:0]   acc_q, acc_d;
   logic [SAD_W-1:0]   min_sad_q, min_sad_d;
   logic [IDX_W-1:0]   min_idx_q, min_idx_d;
   logic [SAD_W-1:0]   best_sad_q, best_sad_d;
   logic [IDX_W-1:0]   best_idx_q, best_idx_d;
   logic               done_q, done_d;

   logic [RS_W-1:0]    row_sum;
   logic [SAD_W-1:0]   cand_sad;
   logic               beat_ok;
   logic               beat_last_row;
   logic               beat_last_cand;

   always_comb begin
      row_sum = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         row_sum = row_sum + RS_W'(ad[i*8 +: 8]);
      end
   end

   assign cand_sad       = acc_q + SAD_W'(rs_q);
   assign beat_ok        = (state_q == ACC) && ad_valid;
   assign beat_last_row  = (row_cnt_q == LAST_ROW);
   assign beat_last_cand = (cand_cnt_q == LAST_CAND);

   always_comb begin
      state_d        = state_q;
      row_cnt_d      = row_cnt_q;
      cand_cnt_d     = cand_cnt_q;
      rs_d           = rs_q;
      rs_valid_d     = 1'b0;
      rs_last_row_d  = rs_last_row_q;
      rs_last_cand_d = rs_last_cand_q;
      rs_cand_d      = rs_cand_q;
      acc_d          = acc_q;
      min_sad_d      = min_sad_q;
      min_idx_d      = min_idx_q;
      best_sad_d     = best_sad_q;
      best_idx_d     = best_idx_q;
      done_d         = 1'b0;

      if (beat_ok) begin
         rs_d           = row_sum;
         rs_valid_d     = 1'b1;
         rs_last_row_d  = beat_last_row;
         rs_last_cand_d = beat_last_cand;
         rs_cand_d      = cand_cnt_q;
         if (beat_last_row) begin
            row_cnt_d  = '0;
            cand_cnt_d = cand_cnt_q + 1'b1;
            if (beat_last_cand) begin
               cand_cnt_d = '0;
               state_d    = FLUSH;
            end
         end else begin
            row_cnt_d = row_cnt_q + 1'b1;
         end
      end

      if (rs_valid_q) begin
         if (!rs_last_row_q) begin
            acc_d = cand_sad;
         end else begin
            acc_d = '0;
            // Strict less-than: on a tie the earlier candidate stays the minimum.
            if ((rs_cand_q == '0) || (cand_sad < min_sad_q)) begin
               min_sad_d = cand_sad;
               min_idx_d = rs_cand_q;
            end
            if (rs_last_cand_q) begin
               best_sad_d = min_sad_d;
               best_idx_d = min_idx_d;
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
      end

      // start wins over everything: aborts any search in flight, including its pending done.
      if (start) begin
         state_d    = ACC;
         row_cnt_d  = '0;
         cand_cnt_d = '0;
         rs_valid_d = 1'b0;
         acc_d      = '0;
         min_sad_d  = '0;
         min_idx_d  = '0;
         best_sad_d = best_sad_q;
         best_idx_d = best_idx_q;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         row_cnt_q      <= '0;
         cand_cnt_q     <= '0;
         rs_q           <= '0;
         rs_valid_q     <= 1'b0;
         rs_last_row_q  <= 1'b0;
         rs_last_cand_q <= 1'b0;
         rs_cand_q      <= '0;
         acc_q          <= '0;
         min_sad_q      <= '0;
         min_idx_q      <= '0;
         best_sad_q     <= '0;
         best_idx_q     <= '0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_cnt_q      <= row_cnt_d;
         cand_cnt_q     <= cand_cnt_d;
         rs_q           <= rs_d;
         rs_valid_q     <= rs_valid_d;
         rs_last_row_q  <= rs_last_row_d;
         rs_last_cand_q <= rs_last_cand_d;
         rs_cand_q      <= rs_cand_d;
         acc_q          <= acc_d;
         min_sad_q      <= min_sad_d;
         min_idx_q      <= min_idx_d;
         best_sad_q     <= best_sad_d;
         best_idx_q     <= best_idx_d;
         done_q         <= done_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign best_sad = best_sad_q;
   assign best_idx = best_idx_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed bench for sad_min_tracker: full searches with hand-computed best SAD/index,
// done latency, ties, ad_valid gaps, abort via start (mid-search and in FLUSH) and reset.
module tb_sad_min_tracker;

   localparam int ARRAY_SIZE = 16;
   localparam int ROWS       = 16;
   localparam int NUM_CAND   = 81;
   localparam int AD_W       = ARRAY_SIZE * 8;
   localparam int SAD_W      = 16;
   localparam int IDX_W      = 7;
   localparam int BEATS      = ROWS * NUM_CAND;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             ad_valid;
   logic [AD_W-1:0]  ad;
   logic             busy;
   logic             done;
   logic [SAD_W-1:0] best_sad;
   logic [IDX_W-1:0] best_idx;

   int n_tests  = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int cnt_base = 0;
   int last_sad = 0;
   int last_idx = 0;

   sad_min_tracker #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .ROWS       (ROWS),
      .NUM_CAND   (NUM_CAND)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .ad_valid (ad_valid),
      .ad       (ad),
      .busy     (busy),
      .done     (done),
      .best_sad (best_sad),
      .best_idx (best_idx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scenario patterns:
   //   0: all zero
   //   1: every lane = 1 for candidate 40, else 5
   //   2: every lane = 254 for candidate 80, else 255
   //   3: candidates 7 and 30 have a single 100 (lane 3, row 2); others one value 101..150 (lane 15, row 15)
   function automatic logic [AD_W-1:0] beat_ad(input int scn, input int c, input int r);
      logic [AD_W-1:0] v;
      v = '0;
      case (scn)
         1: for (int i = 0; i < ARRAY_SIZE; i++) v[i*8 +: 8] = (c == 40) ? 8'd1 : 8'd5;
         2: for (int i = 0; i < ARRAY_SIZE; i++) v[i*8 +: 8] = (c == 80) ? 8'd254 : 8'd255;
         3: begin
            if (c == 7 || c == 30) begin
               if (r == 2) v[3*8 +: 8] = 8'd100;
            end else if (r == 15) begin
               v[15*8 +: 8] = 8'(101 + (c % 50));
            end
         end
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic drive_beats(input int scn, input int gaps, input int n);
      for (int b = 0; b < n; b++) begin
         if (gaps != 0) begin
            int ng;
            ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++) begin
               ad_valid = 1'b0;
               ad       = {$urandom, $urandom, $urandom, $urandom};
               tick();
            end
         end
         ad_valid = 1'b1;
         ad       = beat_ad(scn, b / ROWS, b % ROWS);
         tick();
      end
      ad_valid = 1'b0;
      ad       = '0;
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      tick();
      start    = 1'b0;
      cnt_base = done_cnt;
      check_eq({tag, "_busy_on_start"}, 32'(busy), 32'd1);
      check_eq({tag, "_done_on_start"}, 32'(done), 32'd0);
   endtask

   // Called in the cycle right after the final beat's edge: done must appear one cycle later.
   task automatic finish_check(input string tag, input int exp_sad, input int exp_idx);
      check_eq({tag, "_done_early"}, 32'(done), 32'd0);
      check_eq({tag, "_busy_flush"}, 32'(busy), 32'd1);
      tick();
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
      check_eq({tag, "_best_sad"}, 32'(best_sad), 32'(exp_sad));
      check_eq({tag, "_best_idx"}, 32'(best_idx), 32'(exp_idx));
      check_eq({tag, "_stray_done"}, 32'(done_cnt), 32'(cnt_base));
      last_sad = exp_sad;
      last_idx = exp_idx;
   endtask

   task automatic check_best_held(input string tag);
      check_eq({tag, "_held_sad"}, 32'(best_sad), 32'(last_sad));
      check_eq({tag, "_held_idx"}, 32'(best_idx), 32'(last_idx));
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      ad_valid = 1'b0;
      ad       = '0;
      repeat (3) tick();
      rst = 1'b0;
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_done", 32'(done), 32'd0);
      check_eq("reset_sad", 32'(best_sad), 32'd0);
      check_eq("reset_idx", 32'(best_idx), 32'd0);

      do_start("zero");
      drive_beats(0, 0, BEATS);
      finish_check("zero", 0, 0);

      // Each following start is raised in the done cycle of the previous search.
      do_start("lane1");
      drive_beats(1, 0, BEATS);
      finish_check("lane1", 256, 40);

      do_start("full");
      drive_beats(2, 0, BEATS);
      finish_check("full", 65024, 80);

      do_start("tie");
      drive_beats(3, 0, BEATS);
      finish_check("tie", 100, 7);

      do_start("gaps");
      drive_beats(1, 1, BEATS);
      finish_check("gaps", 256, 40);

      // Abort at candidate 20, row 5; the beat presented with start must be dropped.
      do_start("abort_mid");
      drive_beats(2, 0, 20 * ROWS + 5);
      start    = 1'b1;
      ad_valid = 1'b1;
      ad       = '0;
      tick();
      start    = 1'b0;
      ad_valid = 1'b0;
      cnt_base = done_cnt;
      check_eq("abort_mid_busy", 32'(busy), 32'd1);
      check_best_held("abort_mid");
      drive_beats(3, 1, BEATS);
      finish_check("after_mid", 100, 7);

      // Abort in the FLUSH cycle suppresses the pending done.
      do_start("abort_flush");
      drive_beats(2, 0, BEATS);
      start = 1'b1;
      tick();
      start    = 1'b0;
      cnt_base = done_cnt;
      check_eq("abort_flush_done", 32'(done), 32'd0);
      check_eq("abort_flush_busy", 32'(busy), 32'd1);
      check_best_held("abort_flush");
      drive_beats(1, 0, BEATS);
      finish_check("after_flush", 256, 40);

      // Reset mid-search, then beats without start must be ignored.
      do_start("rst_mid");
      drive_beats(2, 0, 100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rst_mid_busy", 32'(busy), 32'd0);
      check_eq("rst_mid_done", 32'(done), 32'd0);
      check_eq("rst_mid_sad", 32'(best_sad), 32'd0);
      check_eq("rst_mid_idx", 32'(best_idx), 32'd0);
      cnt_base = done_cnt;
      drive_beats(2, 0, 2 * ROWS);
      tick();
      tick();
      check_eq("idle_beats_busy", 32'(busy), 32'd0);
      check_eq("idle_beats_done_cnt", 32'(done_cnt), 32'(cnt_base));
      check_eq("idle_beats_sad", 32'(best_sad), 32'd0);

      do_start("after_rst");
      drive_beats(2, 1, BEATS);
      finish_check("after_rst", 65024, 80);
      tick();
      check_eq("final_done_low", 32'(done), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sad_min_tracker.md
# sad_min_tracker

Downstream consumer of the PE line. Each valid beat takes the ARRAY_SIZE packed 8-bit absolute differences the PE line produces for one row and reduces them to a row sum. It accumulates ROWS row sums into one candidate SAD and tracks the minimum SAD and its candidate index across NUM_CAND candidates. It reports the best match with a one-cycle done pulse to the motion-vector stage.

## Interface
- ARRAY_SIZE, 16, number of 8-bit AD lanes per beat (must match PE line)
- ROWS, 16, row beats per candidate
- NUM_CAND, 81, candidates per search
- Derived (localparams):
  - RS_W = 8+clog2(ARRAY_SIZE)
  - SAD_W = RS_W+clog2(ROWS)
  - IDX_W = clog2(NUM_CAND)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a new search (clears minimum, counters)
- ad_valid  in  1  ad holds one row of the current candidate this cycle
- ad  in  ARRAY_SIZE*8  packed ADs; lane i at ad[i*8+:8]
- busy  out  1  search in progress
- done  out  1  one-cycle pulse; best_* valid
- best_sad  out  SAD_W  minimum SAD of the last completed search
- best_idx  out  IDX_W  candidate index (0-based, arrival order) of best_sad

## Operation
- States: IDLE, ACC, FLUSH.
  - IDLE: ad_valid is ignored. start → ACC, busy=1, row_cnt=0, cand_cnt=0, acc=0, pipeline valid cleared.
  - ACC: each beat with ad_valid=1 enters stage 1.
    - Stage 1 registers rs = sum of all lanes (RS_W bits, zero-extended, no truncation), rs_valid, and tags last_row (row_cnt==ROWS-1) and last_cand (cand_cnt==NUM_CAND-1).
    - row_cnt wraps ROWS-1→0 and increments cand_cnt. After the beat tagged last_row && last_cand is accepted → FLUSH.
  - FLUSH: ad_valid ignored; waits for stage 2 to consume the final rs.
- Stage 2 runs on rs_valid:
  - Not last_row: acc ← acc+rs.
  - Last_row: cand_sad = acc+rs, and acc ← 0.
    - cand_sad replaces the minimum if it is the first candidate of the search or cand_sad < min (strict).
    - Ties keep the earlier index.
  - Last_row && last_cand: best_sad/best_idx ← final min/idx, done=1 for one cycle, busy ← 0, state → IDLE.
- best_sad/best_idx hold between searches. They change only at done.
- Arithmetic is exact. SAD_W covers ROWS*ARRAY_SIZE*255. No saturation.
- ad_valid gaps are allowed anywhere in ACC. Counters advance only on accepted beats.
- start while busy: abort and restart.
  - Counters, acc, min and pipeline valid are cleared. No done is issued for the aborted search.
  - best_* keep their previous values.
  - An ad_valid beat in the same cycle as start is dropped.
- start in FLUSH behaves the same: abort, and the pending done is suppressed.

## Timing
- Reset values: busy=0, done=0, best_sad=0, best_idx=0. State IDLE, all counters/acc/min/valids 0.
- rst mid-search: next cycle equals the reset state, with no done pulse.
- start sampled at edge k: busy=1 from cycle k+1. ad_valid is accepted from edge k+1.
- Pipeline latency: the final beat is sampled at edge k. Stage 1 registers at edge k. Stage 2 updates at edge k+1. done=1 and best_* are valid in the cycle after edge k+1, i.e. 2 cycles after the final beat. busy falls at the same edge.
- Throughput: one row beat per cycle. Back-to-back searches are allowed: start may be asserted in the done cycle and is accepted.
- Minimum search length: ROWS*NUM_CAND accepted beats.

## Test plan
- All ADs zero, 81×16 beats back-to-back → done exactly 2 cycles after the last beat; best_sad=0, best_idx=0.
- Candidate c has every lane = (c==40 ? 1 : 5) → best_sad=256, best_idx=40. Repeat with all lanes 255 except candidate 80 = 254 → best_sad=65024, best_idx=80 (checks full width with no overflow).
- Candidates 7 and 30 both have SAD 100 and all others have more → best_idx=7 (strict-less tie rule).
- Random ad_valid gaps (about 50% duty) on the second scenario → same result. done arrives 2 cycles after the last accepted beat, never earlier.
- Abort cases → no done for the aborted search; the next full search yields its own correct result; best_* unchanged until then:
  - start re-asserted mid-search at candidate 20, row 5.
  - start asserted in the FLUSH cycle.
- rst asserted mid-search → next cycle busy=0, done=0, best_sad=0, best_idx=0; the following ad_valid beats are ignored until start.
